tdm_demux16: RTL
================

# tdm_demux16

Time-division demultiplexer: the receive-side counterpart of `mux16`. It accepts a stream of N-bit words, one slot per valid cycle, and steers each word into one of 16 internal slot registers. Each complete 16-word frame is published atomically on 16 registered outputs with a one-cycle `frame_valid` pulse. It sits at the far end of a link whose transmitter walks `mux16`'s `select` from 0 to 15, and it rebuilds the parallel bus from the serialized words.

## Interface

- `N`, default 4, word width in bits
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `in_valid`  input  1  `in_data` carries a word this cycle
- `in_sof`  input  1  start of frame; qualified by `in_valid`; marks the word as slot 0
- `in_data`  input  N  incoming word
- `out00` … `out15`  output  N each  last completed frame, slot k on `out`k
- `frame_valid`  output  1  one-cycle pulse; the out bus was updated on the preceding edge
- `slot`  output  4  slot index the next non-SOF word will occupy
- `error`  output  1  sticky; a short frame was observed

## Operation

- **Shadow buffer.** Internal buffer `shadow[0..14]`, N bits each, not visible at ports. Slot 15 is never stored; it goes directly to `out15`.
- **Idle cycle.** When `in_valid`=0, no state changes and `frame_valid` is 0 on the next cycle.
- **`in_valid`=1, `in_sof`=1:**
  - `shadow[0]` <= `in_data`; `slot` <= 1.
  - If `slot` != 0 at that edge, a partial frame is abandoned: `error` <= 1. The partial contents are discarded and the outputs are not touched.
  - SOF takes priority over all other rules, including when `slot`=15. In that case no publish occurs and `error` is set.
- **`in_valid`=1, `in_sof`=0, `slot` < 15:**
  - `shadow[slot]` <= `in_data`; `slot` <= `slot`+1.
  - A word arriving at `slot`=0 without SOF is accepted as slot 0, so SOF is optional on an aligned stream.
- **`in_valid`=1, `in_sof`=0, `slot`=15 (publish):**
  - `out00`..`out14` <= `shadow[0..14]` and `out15` <= `in_data`, all on the same edge.
  - `slot` <= 0 (wrap-around).
  - `frame_valid` <= 1 for exactly one cycle.
- **Output stability.** Outputs change only on a publish edge or on reset. They never show a mix of two frames.
- **Error flag.** `error` is cleared only by `rst`.
- **Reset.** On any edge with `rst`=1, reset overrides all inputs. Reset values:
  - `out00`..`out15` = 0
  - `shadow` = 0
  - `slot` = 0
  - `frame_valid` = 0
  - `error` = 0
- **Reset mid-frame.** The partial frame is discarded without setting `error`. The next valid word is slot 0.
- **Slot counter.** `slot` is a 4-bit counter. The 15→0 wrap happens only on the publish rule; no other arithmetic is performed.

## Timing

- All outputs are registered; there are no combinational input-to-output paths.
- **Latency.** The 16th word of a frame is sampled at edge E. `out*` and `frame_valid`=1 are visible after E. `frame_valid` returns to 0 after E+1, unless another publish occurs at E+1, which is impossible because a frame takes at least 16 valid cycles.
- **Throughput.** One word per cycle. Back-to-back frames produce a `frame_valid` pulse every 16 cycles when `in_valid` is held at 1.
- **Gaps.** `in_valid` gaps of any length inside a frame are allowed. The frame completes on the 16th accepted word.
- **Slot output.** `slot` updates on the same edge as the word it counts.
- **Error timing.** `error` rises on the edge that samples the offending SOF.

## Test plan

- **Reset:** hold `rst`=1 for 2 cycles with random inputs -> all `out*`=0, `slot`=0, `frame_valid`=0, `error`=0.
- **Single frame:** 16 consecutive valid words with `in_data`=k at slot k and SOF on word 0 ->
  - after the 16th edge, `out`k = k for every k (select=k maps to out=k, mirroring `mux16`'s bench);
  - `frame_valid` high for exactly one cycle;
  - `slot`=0 and `error`=0.
- **Gaps:** same frame with `in_valid` deasserted for 3 cycles after words 4 and 11 ->
  - all `out*` remain 0 until the 16th word;
  - then `out`k = k with a single `frame_valid` pulse.
- **Back-to-back:** frame with data k, then an immediate frame with data 15−k and no SOF ->
  - `frame_valid` pulses 16 cycles apart;
  - after the second pulse, `out00`=15 and `out15`=0.
- **Short frame:** after a good frame of data k, send 5 words of 4'hA, then SOF and a full frame of 4'h5 ->
  - `error`=1 on the SOF edge;
  - `out*` stay at k, with no pulse, until the new frame completes;
  - then all `out*`=5 and `error` stays 1.
- **Reset mid-frame:** after 7 words of a frame, assert `rst` for one cycle ->
  - `slot`=0, all `out*`=0, `error`=0;
  - a following 16-word frame without SOF publishes correctly.

Source files
------------

// File: rtl/tdm_demux16.sv
// Time-division demultiplexer: collects 16 serialized N-bit words into a
// shadow buffer and publishes the whole frame atomically on 16 registered outputs.
module tdm_demux16 #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_sof,
  input  logic [N-1:0] in_data,
  output logic [N-1:0] out00,
  output logic [N-1:0] out01,
  output logic [N-1:0] out02,
  output logic [N-1:0] out03,
  output logic [N-1:0] out04,
  output logic [N-1:0] out05,
  output logic [N-1:0] out06,
  output logic [N-1:0] out07,
  output logic [N-1:0] out08,
  output logic [N-1:0] out09,
  output logic [N-1:0] out10,
  output logic [N-1:0] out11,
  output logic [N-1:0] out12,
  output logic [N-1:0] out13,
  output logic [N-1:0] out14,
  output logic [N-1:0] out15,
  output logic         frame_valid,
  output logic [3:0]   slot,
  output logic         error
);

  localparam logic [3:0] LastSlot = 4'd15;

  logic [N-1:0] shadow_q [0:14];
  logic [N-1:0] shadow_d [0:14];
  logic [N-1:0] out_q    [0:15];
  logic [N-1:0] out_d    [0:15];
  logic [3:0]   slot_q, slot_d;
  logic         frame_valid_q, frame_valid_d;
  logic         error_q, error_d;

  // SOF wins over every other rule; slot 15 bypasses the shadow and lands on out15.
  always_comb begin
    shadow_d      = shadow_q;
    out_d         = out_q;
    slot_d        = slot_q;
    frame_valid_d = 1'b0;
    error_d       = error_q;

    if (in_valid) begin
      if (in_sof) begin
        shadow_d[0] = in_data;
        slot_d      = 4'd1;
        if (slot_q != 4'd0) begin
          error_d = 1'b1;
        end
      end else if (slot_q == LastSlot) begin
        for (int k = 0; k < 15; k++) begin
          out_d[k] = shadow_q[k];
        end
        out_d[15]     = in_data;
        slot_d        = 4'd0;
        frame_valid_d = 1'b1;
      end else begin
        for (int k = 0; k < 15; k++) begin
          if (slot_q == 4'(k)) begin
            shadow_d[k] = in_data;
          end
        end
        slot_d = slot_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 15; k++) begin
        shadow_q[k] <= '0;
      end
      for (int k = 0; k < 16; k++) begin
        out_q[k] <= '0;
      end
      slot_q        <= 4'd0;
      frame_valid_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      for (int k = 0; k < 15; k++) begin
        shadow_q[k] <= shadow_d[k];
      end
      for (int k = 0; k < 16; k++) begin
        out_q[k] <= out_d[k];
      end
      slot_q        <= slot_d;
      frame_valid_q <= frame_valid_d;
      error_q       <= error_d;
    end
  end

  assign out00       = out_q[0];
  assign out01       = out_q[1];
  assign out02       = out_q[2];
  assign out03       = out_q[3];
  assign out04       = out_q[4];
  assign out05       = out_q[5];
  assign out06       = out_q[6];
  assign out07       = out_q[7];
  assign out08       = out_q[8];
  assign out09       = out_q[9];
  assign out10       = out_q[10];
  assign out11       = out_q[11];
  assign out12       = out_q[12];
  assign out13       = out_q[13];
  assign out14       = out_q[14];
  assign out15       = out_q[15];
  assign frame_valid = frame_valid_q;
  assign slot        = slot_q;
  assign error       = error_q;

endmodule
